bus_timer_responder: RTL and testbench
======================================

Name: bus_timer_responder

Overview:
- Memory-mapped timer peripheral that responds to the core's word-addressed memory bus (a/din/dout/rw).
- Uses the same signalling as the boot RAM: a synchronous write when rw=1, and registered read data one cycle after a read.
- The bus decoder asserts cs for the timer's address window. The block counts down a programmable value behind a prescaler and raises a level interrupt on expiry.

Parameters:
- ID_VALUE, 32'h4C494D42, constant returned by the ID register.
- PRESCALE_WIDTH, 16, width of the PRESCALE register and the internal prescale counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- cs  input  1  chip select from the bus decoder; the bus is ignored when 0.
- a  input  32  word address; only a[2:0] is decoded, a[31:3] is ignored.
- din  input  32  write data.
- rw  input  1  1 = write, 0 = read (qualified by cs).
- dout  output  32  registered read data.
- irq  output  1  level interrupt, high while STATUS.expired=1 and CTRL.ie=1.

Behaviour:
- Register map (a[2:0]):
  - 0 CTRL: bit0 en, bit1 reload, bit2 ie; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: 32-bit current count, read/write.
  - 3 PRESCALE: low PRESCALE_WIDTH bits, upper bits read 0.
  - 4 STATUS: bit0 expired; write 1 to clear, write 0 has no effect.
  - 5 ID: reads ID_VALUE, read-only.
  - 6, 7: read 0, writes ignored.
- Reset (async, rst=1): dout=0, irq=0, CTRL=0, LOAD=0, COUNT=0, PRESCALE=0, prescale counter=0, expired=0.
- Reads: when cs=1 and rw=0, dout takes the selected register's value at that posedge. Data is valid the cycle after the request (1-cycle latency). The value returned is the pre-edge value, so a read coinciding with a decrement returns the old count. dout holds otherwise.
- Writes: when cs=1 and rw=1, the selected register updates at the posedge and dout is unchanged.
- Prescaler:
  - While en=1, the prescale counter increments each cycle.
  - When it equals PRESCALE, a tick is generated and the counter returns to 0. PRESCALE=0 therefore gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - While en=0 the prescale counter is held at 0.
  - Any write to CTRL or PRESCALE clears the prescale counter.
- Count state machine, evaluated at a tick:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: expired is set to 1.
    - reload=1: COUNT is loaded from LOAD.
    - reload=0 (one-shot): en is cleared and COUNT stays 0.
  - Expiry therefore occurs at the tick after COUNT reaches 0. A load of L with PRESCALE=0 expires L+1 cycles after enable.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the write wins and the tick is discarded.
  - A bus write to CTRL in the same cycle as a one-shot expiry: the written CTRL value wins; expired is still set.
  - A STATUS write-1-clear in the same cycle as an expiry: the set wins, so expired stays 1.
- irq is registered: it equals expired & ie as of the previous edge, so it follows a STATUS or ie change by one cycle.
- Reset asserted mid-count: all state clears immediately, with no pending expiry or irq surviving. Counting resumes only after software sets en again.
- All arithmetic is unsigned with 32-bit wrap. LOAD=0 with reload=1 expires on every tick.
- Inputs with cs=0 never affect state.

Test Plan:
- Reset, then read each register -> dout=0 for CTRL/LOAD/COUNT/PRESCALE/STATUS, 32'h4C494D42 for ID, and 0 for addresses 6/7; dout is valid exactly one cycle after the read.
- Write COUNT=3, PRESCALE=0, CTRL=3'b101 (en, ie, one-shot) -> COUNT reads 2,1,0; expired=1 on the 4th cycle after enable, irq high the following cycle, then en reads 0 and COUNT stays 0.
- LOAD=2, COUNT=2, PRESCALE=2, CTRL=3'b011 (en, reload) -> COUNT changes every 3 cycles; after expiry COUNT=2 again; expired stays 1 until written 1, and writing 0 has no effect.
- Write STATUS=1 in the same cycle as an expiry -> expired stays 1 and irq remains asserted.
- Write COUNT=100 in the same cycle as a tick while running -> COUNT reads 100 next, not 99; the cs=0 write sequence leaves every register unchanged.
- Assert rst mid-count with irq high -> dout, irq and all registers are 0 immediately; after release with no bus writes, COUNT does not change for 20 cycles.

Source files
------------

// File: rtl/bus_timer_responder.sv
// Memory-mapped countdown timer with prescaler and level interrupt on a word-addressed bus.
// Latency: writes take effect at the request edge; read data is registered, valid one cycle later.
// Backpressure: none; the bus is always accepted when cs=1.
//
// Ports:
//   clk   system clock, all state updates on posedge
//   rst   asynchronous reset, active-high
//   cs    chip select; the bus is ignored while low
//   a     word address, only a[2:0] decoded
//   din   write data
//   rw    1 = write, 0 = read
//   dout  registered read data, holds between reads
//   irq   registered level interrupt, expired & ie as of the previous edge
module bus_timer_responder #(
  parameter logic [31:0] ID_VALUE       = 32'h4C494D42,
  parameter int          PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [31:0] a,
  input  logic [31:0] din,
  input  logic        rw,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_LOAD     = 3'd1;
  localparam logic [2:0] ADDR_COUNT    = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_ID       = 3'd5;

  logic [2:0]                ctrl_q, ctrl_d;       // {ie, reload, en}
  logic [31:0]               load_q, load_d;
  logic [31:0]               count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                      expired_q, expired_d;
  logic                      irq_q, irq_d;
  logic [31:0]               dout_q, dout_d;

  logic [2:0]  sel;
  logic        wr, rd;
  logic        wr_ctrl, wr_count, wr_prescale, wr_status;
  logic        tick, expire;
  logic [31:0] prescale_ext;
  logic        unused_addr;

  assign sel         = a[2:0];
  assign unused_addr = ^a[31:3];
  assign wr          = cs & rw;
  assign rd          = cs & ~rw;
  assign wr_ctrl     = wr && (sel == ADDR_CTRL);
  assign wr_count    = wr && (sel == ADDR_COUNT);
  assign wr_prescale = wr && (sel == ADDR_PRESCALE);
  assign wr_status   = wr && (sel == ADDR_STATUS);

  assign tick = ctrl_q[0] && (pcnt_q == prescale_q);
  // A COUNT write in the same cycle swallows the tick, including any expiry it would cause.
  assign expire = tick && !wr_count && (count_q == 32'd0);

  always_comb begin
    prescale_ext = '0;
    prescale_ext[PRESCALE_WIDTH-1:0] = prescale_q;
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    expired_d  = expired_q;
    dout_d     = dout_q;
    irq_d      = expired_q & ctrl_q[2];

    // Prescaler: restarts on any CTRL/PRESCALE write, parked at 0 while disabled.
    if (wr_ctrl || wr_prescale || !ctrl_q[0] || tick) pcnt_d = '0;
    else                                              pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);

    if (wr_count) begin
      count_d = din;
    end else if (tick) begin
      if (count_q != 32'd0)  count_d = count_q - 32'd1;
      else if (ctrl_q[1])    count_d = load_q;
    end

    // One-shot expiry clears en, but a simultaneous CTRL write takes precedence.
    if (wr_ctrl)                   ctrl_d = din[2:0];
    else if (expire && !ctrl_q[1]) ctrl_d = {ctrl_q[2:1], 1'b0};

    if (wr && (sel == ADDR_LOAD)) load_d = din;
    if (wr_prescale)              prescale_d = din[PRESCALE_WIDTH-1:0];

    // Set beats write-1-clear when both land in the same cycle.
    if (expire)                   expired_d = 1'b1;
    else if (wr_status && din[0]) expired_d = 1'b0;

    if (rd) begin
      case (sel)
        ADDR_CTRL:     dout_d = {29'd0, ctrl_q};
        ADDR_LOAD:     dout_d = load_q;
        ADDR_COUNT:    dout_d = count_q;
        ADDR_PRESCALE: dout_d = prescale_ext;
        ADDR_STATUS:   dout_d = {31'd0, expired_q};
        ADDR_ID:       dout_d = ID_VALUE;
        default:       dout_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
      dout_q     <= dout_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
module tb_bus_timer_responder;

  localparam logic [31:0] ID = 32'h4C494D42;

  logic        clk;
  logic        rst;
  logic        cs;
  logic [31:0] a;
  logic [31:0] din;
  logic        rw;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] sb_exp[$];
  string       sb_nm[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t        rst_tbl[9];
  logic [31:0] cnt_exp[10];

  bus_timer_responder dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .a    (a),
    .din  (din),
    .rw   (rw),
    .dout (dout),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cs = 1'b0;
    rw = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cs  = 1'b1;
    rw  = 1'b1;
    a   = addr;
    din = data;
    cyc();
    cs  = 1'b0;
    rw  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    cs = 1'b1;
    rw = 1'b0;
    a  = addr;
    sb_exp.push_back(exp);
    sb_nm.push_back(nm);
    cyc();
    cs = 1'b0;
    e  = sb_exp.pop_front();
    n  = sb_nm.pop_front();
    chk(n, dout, e);
  endtask

  initial begin
    logic [31:0] e;
    string       n;

    rst = 1'b1; cs = 1'b0; rw = 1'b0; a = '0; din = '0;

    rst_tbl[0] = '{32'd0, 32'd0};
    rst_tbl[1] = '{32'd1, 32'd0};
    rst_tbl[2] = '{32'd2, 32'd0};
    rst_tbl[3] = '{32'd3, 32'd0};
    rst_tbl[4] = '{32'd4, 32'd0};
    rst_tbl[5] = '{32'd5, ID};
    rst_tbl[6] = '{32'hFFFF_FFF5, ID};
    rst_tbl[7] = '{32'd7, 32'd0};
    rst_tbl[8] = '{32'd6, 32'd0};
    cnt_exp    = '{32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};

    // Reset state and register map after reset
    #12;
    chk("rst_dout", dout, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) rd(rst_tbl[i].addr, rst_tbl[i].exp, $sformatf("rst_read_%0d", i));

    // Read latency: dout must not change before the edge that samples the request
    cs = 1'b1; rw = 1'b0; a = 32'd5;
    sb_exp.push_back(ID); sb_nm.push_back("lat_post");
    #2;
    chk("lat_pre", dout, 32'd0);
    cyc();
    cs = 1'b0;
    e = sb_exp.pop_front(); n = sb_nm.pop_front();
    chk(n, dout, e);

    // One-shot countdown from 3 with ie
    wr(32'd2, 32'd3);
    wr(32'd3, 32'd0);
    wr(32'd0, 32'd5);
    idle(1);
    rd(32'd2, 32'd2, "os_cnt2");
    rd(32'd2, 32'd1, "os_cnt1");
    rd(32'd2, 32'd0, "os_cnt0");
    chk("os_irq_lag", {31'd0, irq}, 32'd0);
    rd(32'd4, 32'd1, "os_expired");
    chk("os_irq", {31'd0, irq}, 32'd1);
    rd(32'd0, 32'd4, "os_en_clr");
    rd(32'd2, 32'd0, "os_cnt_hold");
    wr(32'd4, 32'd1);
    idle(1);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);
    wr(32'd0, 32'd0);

    // Periodic reload with prescale 2
    wr(32'd1, 32'd2);
    wr(32'd2, 32'd2);
    wr(32'd3, 32'd2);
    wr(32'd0, 32'd3);
    for (int i = 0; i < 10; i++) rd(32'd2, cnt_exp[i], $sformatf("rl_cnt_%0d", i));
    rd(32'd4, 32'd1, "rl_expired");
    wr(32'd4, 32'd0);
    rd(32'd4, 32'd1, "rl_w0_noeffect");
    wr(32'd4, 32'd1);
    rd(32'd4, 32'd0, "rl_w1_clear");
    chk("rl_irq_ie0", {31'd0, irq}, 32'd0);

    // STATUS clear colliding with an expiry (LOAD=0 reload expires every tick)
    wr(32'd0, 32'd0);
    wr(32'd4, 32'd1);
    wr(32'd1, 32'd0);
    wr(32'd2, 32'd0);
    wr(32'd3, 32'd0);
    wr(32'd0, 32'd7);
    idle(1);
    wr(32'd4, 32'd1);
    rd(32'd4, 32'd1, "col_set_wins");
    chk("col_irq", {31'd0, irq}, 32'd1);

    // CTRL write colliding with a one-shot expiry
    wr(32'd0, 32'd0);
    wr(32'd4, 32'd1);
    wr(32'd2, 32'd0);
    wr(32'd0, 32'd1);
    wr(32'd0, 32'd3);
    rd(32'd0, 32'd3, "col_ctrl_wins");
    rd(32'd4, 32'd1, "col_ctrl_expired");

    // COUNT write colliding with a tick
    wr(32'd0, 32'd0);
    wr(32'd3, 32'd0);
    wr(32'd2, 32'd50);
    wr(32'd0, 32'd1);
    idle(1);
    wr(32'd2, 32'd100);
    rd(32'd2, 32'd100, "cw_write_wins");
    rd(32'd2, 32'd99, "cw_next_tick");

    // Bus activity with cs=0 must not touch state
    wr(32'd0, 32'd0);
    wr(32'd1, 32'd7);
    wr(32'd2, 32'd9);
    wr(32'd3, 32'd5);
    for (int i = 0; i < 8; i++) begin
      cs = 1'b0; rw = 1'b1; a = i; din = 32'hFFFF_FFFF;
      cyc();
    end
    rw = 1'b0;
    rd(32'd0, 32'd0, "cs0_ctrl");
    rd(32'd1, 32'd7, "cs0_load");
    rd(32'd2, 32'd9, "cs0_count");
    rd(32'd3, 32'd5, "cs0_prescale");
    rd(32'd4, 32'd1, "cs0_status");

    // Reset asserted mid-count with irq high
    wr(32'd1, 32'd0);
    wr(32'd2, 32'd0);
    wr(32'd3, 32'd0);
    wr(32'd0, 32'd7);
    idle(3);
    chk("mr_irq_pre", {31'd0, irq}, 32'd1);
    rd(32'd5, ID, "mr_dout_pre");
    rst = 1'b1;
    #1;
    chk("mr_dout_async", dout, 32'd0);
    chk("mr_irq_async", {31'd0, irq}, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) rd(rst_tbl[i].addr, 32'd0, $sformatf("mr_read_%0d", i));
    idle(20);
    rd(32'd2, 32'd0, "mr_count_idle");
    rd(32'd4, 32'd0, "mr_status_idle");
    chk("mr_irq_idle", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
